regf_burst_ctrl: RTL and testbench

Burst access controller sitting directly upstream of the dual-port configuration register file. It accepts one read or write command (start address plus beat count) from the interface frame logic. It streams write data into the register file's write port, or streams read data out of its 1-cycle-latency read port through a valid/ready channel. A 2-entry output buffer with credit-based read issue sustains one beat per cycle without losing data under backpressure.

---
 rtl/regf_burst_ctrl_pkg.sv | 16 +
 rtl/regf_burst_ctrl_rd_skid.sv | 55 +++++
 rtl/regf_burst_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_regf_burst_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regf_burst_ctrl_pkg.sv
// Shared types and constants for the register-file burst controller.
package regf_ctrl_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int ADDR_DEF   = 15;
  localparam int LEN_W_DEF  = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/regf_burst_ctrl_rd_skid.sv
// Two-entry FIFO of {last, data} that buffers register-file read returns
// ahead of the valid/ready read channel.
module regf_rd_skid
  import regf_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             push_last_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic             valid_o,
  output logic             last_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH:0] mem_q [FIFO_DEPTH];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     occ_q;

  // Storage, pointers and occupancy; push and pop together keep occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = (occ_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign last_o  = mem_q[rd_ptr_q][WIDTH] & valid_o;

endmodule

// File: rtl/regf_burst_ctrl.sv
// Burst access controller in front of the dual-port configuration register
// file: streams write beats into the write port, read beats out via a skid FIFO.
module regf_burst_ctrl
  import regf_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rnw,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_last,
  output logic             done,
  output logic             busy,
  output logic             regf_wr_en,
  output logic [ADDR-1:0]  regf_wr_addr,
  output logic [WIDTH-1:0] regf_wr_data,
  output logic             regf_rd_en,
  output logic [ADDR-1:0]  regf_rd_addr,
  input  logic [WIDTH-1:0] regf_rd_data
);

  localparam int CNT_W = LEN_W + 1;

  state_e           state_q, state_d;
  logic [ADDR-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             inflight_q;
  logic             rd_last_q, rd_last_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             done_q, done_d;

  logic             cmd_hs_s;
  logic             wr_hs_s;
  logic             pop_s;
  logic             last_beat_s;
  logic             credit_s;
  logic             rd_en_s;
  logic [1:0]       occ_s;
  logic             fifo_valid_s;
  logic             fifo_last_s;
  logic [WIDTH-1:0] fifo_data_s;

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wdata_ready = (state_q == WR);
  assign cmd_hs_s    = cmd_valid & cmd_ready;
  assign wr_hs_s     = wdata_valid & wdata_ready;
  assign pop_s       = fifo_valid_s & rdata_ready;
  assign last_beat_s = (beat_q == {1'b0, len_q});

  // A read may issue only if its return is guaranteed a FIFO slot.
  assign credit_s = (({1'b0, occ_s} + {2'b00, inflight_q}) < (3'(FIFO_DEPTH) + {2'b00, pop_s}));
  assign rd_en_s  = (state_q == RD_ISSUE) && (beat_q <= {1'b0, len_q}) && credit_s;

  // Next-state, counters and registered write-port outputs.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rd_last_d  = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_hs_s) begin
          cur_addr_d = cmd_addr;
          len_d      = cmd_len;
          beat_d     = '0;
          state_d    = cmd_rnw ? RD_ISSUE : WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (wr_hs_s) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = cur_addr_q;
          wr_data_d  = wdata;
          cur_addr_d = cur_addr_q + ADDR'(1);
          beat_d     = beat_q + CNT_W'(1);
          if (last_beat_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WR;
          end
        end else begin
          state_d = WR;
        end
      end
      RD_ISSUE: begin
        if (rd_en_s) begin
          cur_addr_d = cur_addr_q + ADDR'(1);
          beat_d     = beat_q + CNT_W'(1);
          rd_last_d  = last_beat_s;
          state_d    = last_beat_s ? RD_DRAIN : RD_ISSUE;
        end else begin
          state_d = RD_ISSUE;
        end
      end
      RD_DRAIN: begin
        if (pop_s && fifo_last_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD_DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      inflight_q <= rd_en_s;
      rd_last_q  <= rd_last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  regf_rd_skid #(
    .WIDTH(WIDTH)
  ) u_rd_skid (
    .clk        (clk),
    .reset      (reset),
    .push_i     (inflight_q),
    .push_last_i(rd_last_q),
    .push_data_i(regf_rd_data),
    .pop_i      (pop_s),
    .occ_o      (occ_s),
    .valid_o    (fifo_valid_s),
    .last_o     (fifo_last_s),
    .data_o     (fifo_data_s)
  );

  assign rdata_valid  = fifo_valid_s;
  assign rdata_last   = fifo_last_s;
  assign rdata        = fifo_data_s;
  assign done         = done_q;
  assign regf_wr_en   = wr_en_q;
  assign regf_wr_addr = wr_addr_q;
  assign regf_wr_data = wr_data_q;
  assign regf_rd_en   = rd_en_s;
  assign regf_rd_addr = cur_addr_q;

endmodule

// File: tb/tb_regf_burst_ctrl.sv
// Directed bench for regf_burst_ctrl with a behavioural register-file model.
module tb_regf_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [7:0]  wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [7:0]  rdata;
  logic        done, busy;
  logic        regf_wr_en, regf_rd_en;
  logic [14:0] regf_wr_addr, regf_rd_addr;
  logic [7:0]  regf_wr_data, regf_rd_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] rf [0:32767];
  logic [7:0] burst_data [4];

  always #5 clk = ~clk;

  // Register-file model: 1-cycle read latency.
  always @(posedge clk) begin
    if (regf_wr_en) rf[regf_wr_addr] <= regf_wr_data;
    if (regf_rd_en) regf_rd_data <= rf[regf_rd_addr];
  end

  regf_burst_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .busy(busy),
    .regf_wr_en(regf_wr_en), .regf_wr_addr(regf_wr_addr), .regf_wr_data(regf_wr_data),
    .regf_rd_en(regf_rd_en), .regf_rd_addr(regf_rd_addr), .regf_rd_data(regf_rd_data)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
    end
    tests_run++;
    if ({wdata_ready, rdata_valid, rdata, rdata_last, done, busy, regf_wr_en, regf_wr_addr,
         regf_wr_data, regf_rd_en, regf_rd_addr} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got nonzero outputs exp all 0 (busy=%b rv=%b we=%b re=%b)",
               busy, rdata_valid, regf_wr_en, regf_rd_en);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_burst();
    int k;
    logic exp_en;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 15'h0010; cmd_len = 8'd3;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      wdata_valid = (c <= 4);
      wdata       = (c <= 4) ? burst_data[c-1] : 8'h00;
      #1;
      k      = (c >= 2) ? c - 2 : 0;
      exp_en = (c >= 2) && (c <= 5);
      tests_run++;
      if (regf_wr_en !== exp_en || done !== (c == 5) ||
          (exp_en && (regf_wr_addr !== 15'(16 + k) || regf_wr_data !== burst_data[k]))) begin
        tests_failed++;
        $display("FAIL wr_burst c%0d got en=%b addr=%h data=%h done=%b exp en=%b addr=%h data=%h done=%b",
                 c, regf_wr_en, regf_wr_addr, regf_wr_data, done, exp_en, 15'(16 + k),
                 burst_data[k], (c == 5));
      end
      if (c <= 4) begin
        tests_run++;
        if (wdata_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL wr_ready c%0d got %b exp 1", c, wdata_ready);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL wr_busy_after got %b exp 0", busy);
        end
      end
    end
  endtask

  task automatic test_read_burst();
    logic exp_v;
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 15'h0010; cmd_len = 8'd3; rdata_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (c == 1) begin
        tests_run++;
        if (regf_rd_en !== 1'b1 || regf_rd_addr !== 15'h0010) begin
          tests_failed++;
          $display("FAIL rd_issue got en=%b addr=%h exp en=1 addr=0010", regf_rd_en, regf_rd_addr);
        end
      end
      exp_v = (c >= 3) && (c <= 6);
      k     = exp_v ? c - 3 : 0;
      tests_run++;
      if (rdata_valid !== exp_v || done !== (c == 7) ||
          (exp_v && (rdata !== burst_data[k] || rdata_last !== (c == 6)))) begin
        tests_failed++;
        $display("FAIL rd_burst c%0d got v=%b d=%h last=%b done=%b exp v=%b d=%h last=%b done=%b",
                 c, rdata_valid, rdata, rdata_last, done, exp_v, burst_data[k], (c == 6), (c == 7));
      end
    end
  endtask

  task automatic test_read_backpressure();
    logic [7:0] got [$];
    logic       got_last [$];
    int         issued = 0;
    int         popped = 0;
    int         max_out = 0;
    logic       seen_done = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 15'h0010; cmd_len = 8'd3; rdata_ready = 1'b1;
    for (int c = 1; c <= 40 && !seen_done; c++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      rdata_ready = !(c >= 4 && c <= 8);
      #1;
      if (stall_prev) begin
        tests_run++;
        if (rdata_valid !== 1'b1 || rdata !== data_prev) begin
          tests_failed++;
          $display("FAIL bp_stable c%0d got v=%b d=%h exp v=1 d=%h", c, rdata_valid, rdata, data_prev);
        end
      end
      if (regf_rd_en === 1'b1) issued++;
      if (rdata_valid === 1'b1 && rdata_ready) begin
        got.push_back(rdata);
        got_last.push_back(rdata_last);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      stall_prev = (rdata_valid === 1'b1) && !rdata_ready;
      data_prev  = rdata;
      if (done === 1'b1) seen_done = 1'b1;
    end
    rdata_ready = 1'b1;
    tests_run++;
    if (!seen_done) begin
      tests_failed++;
      $display("FAIL bp_done got no done within 40 cycles exp done");
    end
    tests_run++;
    if (max_out > 2) begin
      tests_failed++;
      $display("FAIL bp_outstanding got %0d exp <=2", max_out);
    end
    tests_run++;
    if (got.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count got %0d beats exp 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got[i] !== burst_data[i] || got_last[i] !== (i == 3)) begin
          tests_failed++;
          $display("FAIL bp_beat%0d got d=%h last=%b exp d=%h last=%b",
                   i, got[i], got_last[i], burst_data[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] wv [2];
    logic [14:0] wa [2];
    wv[0] = 8'h5A; wv[1] = 8'hC3;
    wa[0] = 15'h7FFF; wa[1] = 15'h0000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 15'h7FFF; cmd_len = 8'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      wdata_valid = (c <= 2);
      wdata       = (c <= 2) ? wv[c-1] : 8'h00;
      if (c == 3) begin
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 15'h7FFF; cmd_len = 8'd1; rdata_ready = 1'b1;
      end
      #1;
      if (c >= 2) begin
        tests_run++;
        if (regf_wr_en !== 1'b1 || regf_wr_addr !== wa[c-2] || regf_wr_data !== wv[c-2] ||
            done !== (c == 3)) begin
          tests_failed++;
          $display("FAIL wrap_wr c%0d got en=%b addr=%h data=%h done=%b exp en=1 addr=%h data=%h done=%b",
                   c, regf_wr_en, regf_wr_addr, regf_wr_data, done, wa[c-2], wv[c-2], (c == 3));
        end
      end
      if (c == 3) begin
        tests_run++;
        if (cmd_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_cmd_ready got %b exp 1", cmd_ready);
        end
      end
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (c >= 3 && c <= 4) begin
        tests_run++;
        if (rdata_valid !== 1'b1 || rdata !== wv[c-3] || rdata_last !== (c == 4)) begin
          tests_failed++;
          $display("FAIL wrap_rd c%0d got v=%b d=%h last=%b exp v=1 d=%h last=%b",
                   c, rdata_valid, rdata, rdata_last, wv[c-3], (c == 4));
        end
      end
      if (c == 5) begin
        tests_run++;
        if (done !== 1'b1 || rdata_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL wrap_rd_done got done=%b v=%b exp done=1 v=0", done, rdata_valid);
        end
      end
    end
  endtask

  task automatic test_write_len0_delay();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 15'h0200; cmd_len = 8'd0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      wdata_valid = (c == 4);
      wdata       = (c == 4) ? 8'h99 : 8'h00;
      #1;
      if (c <= 4) begin
        tests_run++;
        if (wdata_ready !== 1'b1 || regf_wr_en !== 1'b0 || done !== 1'b0) begin
          tests_failed++;
          $display("FAIL len0_wait c%0d got rdy=%b en=%b done=%b exp rdy=1 en=0 done=0",
                   c, wdata_ready, regf_wr_en, done);
        end
      end else begin
        tests_run++;
        if (regf_wr_en !== (c == 5) || done !== (c == 5) ||
            (c == 5 && (regf_wr_addr !== 15'h0200 || regf_wr_data !== 8'h99))) begin
          tests_failed++;
          $display("FAIL len0_wr c%0d got en=%b addr=%h data=%h done=%b exp en=%b addr=0200 data=99 done=%b",
                   c, regf_wr_en, regf_wr_addr, regf_wr_data, done, (c == 5), (c == 5));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 15'h0010; cmd_len = 8'd15; rdata_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1 || {wdata_ready, rdata_valid, rdata, rdata_last, done, busy, regf_wr_en,
        regf_wr_addr, regf_wr_data, regf_rd_en, regf_rd_addr} !== 64'd0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got cmd_ready=%b busy=%b rv=%b re=%b rdata=%h exp cmd_ready=1 others 0",
               cmd_ready, busy, rdata_valid, regf_rd_en, rdata);
    end
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (regf_rd_en !== 1'b0 || rdata_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrst_quiet c%0d got re=%b rv=%b busy=%b exp 0 0 0",
                 c, regf_rd_en, rdata_valid, busy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rf[i] = 8'h00;
    burst_data[0] = 8'hA0; burst_data[1] = 8'hA1; burst_data[2] = 8'hA2; burst_data[3] = 8'hA3;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 15'h0000; cmd_len = 8'd0;
    wdata_valid = 1'b0; wdata = 8'h00; rdata_ready = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_backpressure();
    test_wrap();
    test_write_len0_delay();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
